pipeline_hazard_ctrl: RTL and testbench

// - Central stall/flush sequencer for the 5-stage RV32I core; sits beside the forwarding unit.
// - Forwarding covers EX/MEM->EX and MEM/WB->EX; this block covers the hazards forwarding cannot.
// - Those hazards are load-use, instruction-memory wait, data-memory wait and taken-branch redirect.
// - Drives per-stage stall (hold) and flush (bubble) enables, and tracks squashed fetches.
// - Also keeps a wait timeout and a stall performance counter.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the RV32I hazard sequencer: sequencer state and the
// packed per-stage stall/flush bundle used at the top-level connection.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } hz_state_t;

    // stall: [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb
    // flush: [0]=if_id [1]=id_ex
    typedef struct packed {
        logic [4:0] stall;
        logic [1:0] flush;
    } stage_ctrl_t;

    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, imem/dmem waits and
// taken-branch redirects, with squashed-fetch tracking, wait timeout and stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 1024,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1_s,
    input  logic [4:0]             id_rs2_s,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             id_ex_rd,
    input  logic                   id_ex_mem_read,
    input  logic                   imem_req,
    input  logic                   imem_resp,
    input  logic                   dmem_req,
    input  logic                   dmem_resp,
    input  logic                   ex_br_taken,
    output logic                   pc_stall,
    output logic                   if_id_stall,
    output logic                   id_ex_stall,
    output logic                   ex_mem_stall,
    output logic                   mem_wb_stall,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   imem_resp_discard,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int WC_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    hz_state_t   state, state_next;
    stage_ctrl_t ctrl;
    logic        squash, squash_next;
    logic        i_pend, i_pend_next;
    logic        d_busy, i_busy, discard, lu, lu_hold;
    logic        timeout_hit;
    logic [WC_W-1:0] wait_cnt;

    always_comb begin
        ctrl        = '0;
        discard     = imem_resp & squash;
        d_busy      = (dmem_req | (state == D_WAIT)) & ~dmem_resp;
        i_busy      = (imem_req | i_pend) & (~imem_resp | discard);
        lu          = load_use_hit(id_ex_mem_read, id_ex_rd, id_rs1_s, id_rs2_s,
                                   id_uses_rs1, id_uses_rs2);
        lu_hold     = lu & ~ex_br_taken;

        if (d_busy) begin
            ctrl.stall = '1;
        end else begin
            ctrl.stall[0] = lu_hold | i_busy;
            ctrl.stall[1] = lu_hold;
            // A held ID instruction must not be replaced by the fetch bubble.
            ctrl.flush[0] = ex_br_taken | (i_busy & ~lu_hold);
            ctrl.flush[1] = ex_br_taken | lu;
        end
        if (!rst_n) ctrl = '0;

        // Fetch stays outstanding through a discarded response (refetch).
        i_pend_next = (i_pend | imem_req) & ~(imem_resp & ~discard);
        squash_next = (squash & ~imem_resp) | (ex_br_taken & ~d_busy & i_busy);

        state_next = RUN;
        if (d_busy)           state_next = D_WAIT;
        else if (i_pend_next) state_next = I_WAIT;
    end

    assign timeout_hit = (WAIT_TIMEOUT != 0) && (state != RUN) &&
                         (wait_cnt == WC_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            squash      <= 1'b0;
            i_pend      <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state  <= state_next;
            squash <= squash_next;
            i_pend <= i_pend_next;
            if (timeout_hit) mem_timeout <= 1'b1;
        end
    end

    sat_counter #(.W(WC_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != RUN),
        .clr   (state_next == RUN),
        .count (wait_cnt)
    );

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.stall[0]),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    assign pc_stall          = ctrl.stall[0];
    assign if_id_stall       = ctrl.stall[1];
    assign id_ex_stall       = ctrl.stall[2];
    assign ex_mem_stall      = ctrl.stall[3];
    assign mem_wb_stall      = ctrl.stall[4];
    assign if_id_flush       = ctrl.flush[0];
    assign id_ex_flush       = ctrl.flush[1];
    assign imem_resp_discard = discard & rst_n;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; one task per scenario.
module tb_pipeline_hazard_ctrl;

    localparam int WT = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1_s, id_rs2_s, id_ex_rd;
    logic          id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic          imem_req, imem_resp, dmem_req, dmem_resp, ex_br_taken;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic          if_id_flush, id_ex_flush, imem_resp_discard, mem_timeout;
    logic [SW-1:0] stall_cycles;
    logic [7:0]    obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WAIT_TIMEOUT(WT), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_s(id_rs1_s), .id_rs2_s(id_rs2_s),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .imem_resp_discard(imem_resp_discard),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb stall, if_id flush, id_ex flush, discard}
    assign obs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                  if_id_flush, id_ex_flush, imem_resp_discard};

    task automatic clear_inputs();
        id_rs1_s = 5'd0; id_rs2_s = 5'd0; id_ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_mem_read = 1'b0;
        imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
        ex_br_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        imem_req = 1'b1;
        dmem_req = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; id_rs1_s = 5'd3; id_uses_rs1 = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (obs !== 8'b0) begin
            errors++; $display("FAIL reset_outputs got=%b want=%b", obs, 8'b0);
        end
        checks++;
        if (stall_cycles !== '0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_counters got=%0d/%b want=0/0", stall_cycles, mem_timeout);
        end
        do_reset();
        #3;
        checks++;
        if (obs !== 8'b0) begin
            errors++; $display("FAIL idle_after_reset got=%b want=%b", obs, 8'b0);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        tick();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; id_rs1_s = 5'd5; id_uses_rs1 = 1'b1;
        #3;
        checks++;
        if (obs !== 8'b11000_010) begin
            errors++; $display("FAIL load_use_rs1 got=%b want=%b", obs, 8'b11000_010);
        end
        tick();
        id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
        #3;
        checks++;
        if (obs !== 8'b0) begin
            errors++; $display("FAIL load_use_after_bubble got=%b want=%b", obs, 8'b0);
        end
    endtask

    task automatic test_no_hazard();
        logic [4:0] rd_v [3]  = '{5'd0, 5'd7, 5'd7};
        logic       use2  [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] exp_v [3] = '{8'b0, 8'b0, 8'b11000_010};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            clear_inputs();
            id_ex_mem_read = 1'b1; id_ex_rd = rd_v[i];
            id_rs1_s = (i == 0) ? 5'd0 : 5'd2; id_uses_rs1 = 1'b1;
            id_rs2_s = rd_v[i]; id_uses_rs2 = use2[i];
            #3;
            checks++;
            if (obs !== exp_v[i]) begin
                errors++; $display("FAIL no_hazard_case%0d got=%b want=%b", i, obs, exp_v[i]);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_dmem_wait();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            dmem_req  = (c == 0);
            dmem_resp = (c == 3);
            #3;
            checks++;
            if (obs !== ((c < 3) ? 8'b11111_000 : 8'b0)) begin
                errors++; $display("FAIL dmem_wait_c%0d got=%b want=%b", c, obs,
                                   (c < 3) ? 8'b11111_000 : 8'b0);
            end
        end
        tick();
        dmem_resp = 1'b0;
        checks++;
        if (stall_cycles !== SW'(3)) begin
            errors++; $display("FAIL dmem_stall_count got=%0d want=3", stall_cycles);
        end
        #3;
        checks++;
        if (obs !== 8'b0) begin
            errors++; $display("FAIL dmem_after_wait got=%b want=%b", obs, 8'b0);
        end
    endtask

    task automatic test_branch_in_dwait();
        logic [7:0] exp_v [5] = '{8'b11111_000, 8'b11111_000, 8'b11111_000,
                                  8'b00000_110, 8'b0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            dmem_req    = (c == 0);
            ex_br_taken = (c >= 1 && c <= 3);
            dmem_resp   = (c == 3);
            #3;
            checks++;
            if (obs !== exp_v[c]) begin
                errors++; $display("FAIL br_in_dwait_c%0d got=%b want=%b", c, obs, exp_v[c]);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_squash();
        logic [7:0] exp_v [7] = '{8'b10000_100, 8'b10000_110, 8'b10000_100,
                                  8'b10000_101, 8'b10000_100, 8'b0, 8'b0};
        int discards = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            tick();
            imem_req    = (c == 0);
            ex_br_taken = (c == 1);
            imem_resp   = (c == 3 || c == 5);
            #3;
            if (imem_resp_discard) discards++;
            checks++;
            if (obs !== exp_v[c]) begin
                errors++; $display("FAIL squash_c%0d got=%b want=%b", c, obs, exp_v[c]);
            end
        end
        checks++;
        if (discards != 1) begin
            errors++; $display("FAIL squash_discard_count got=%0d want=1", discards);
        end
        checks++;
        if (stall_cycles !== SW'(5)) begin
            errors++; $display("FAIL squash_stall_count got=%0d want=5", stall_cycles);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        dmem_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            dmem_req = 1'b0;
            #3;
            checks++;
            if (mem_timeout !== (k >= 5)) begin
                errors++; $display("FAIL timeout_k%0d got=%b want=%b", k, mem_timeout, k >= 5);
            end
        end
        tick();
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        tick();
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got=%b want=1", mem_timeout);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        tick();
        imem_req = 1'b1;
        repeat (20) tick();
        checks++;
        if (stall_cycles !== {SW{1'b1}}) begin
            errors++; $display("FAIL stall_saturate got=%0d want=%0d", stall_cycles, (1 << SW) - 1);
        end
        imem_req = 1'b0;
        imem_resp = 1'b1;
        tick();
        imem_resp = 1'b0;
        tick();
        checks++;
        if (stall_cycles !== {SW{1'b1}}) begin
            errors++; $display("FAIL stall_no_wrap got=%0d want=%0d", stall_cycles, (1 << SW) - 1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        imem_req = 1'b1;
        tick();
        imem_req = 1'b0; ex_br_taken = 1'b1;
        tick();
        ex_br_taken = 1'b0;
        #2;
        checks++;
        if (obs !== 8'b10000_100) begin
            errors++; $display("FAIL pre_reset_iwait got=%b want=%b", obs, 8'b10000_100);
        end
        rst_n = 1'b0;
        imem_req = 1'b1;
        #1;
        checks++;
        if (obs !== 8'b0 || stall_cycles !== '0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL async_reset got=%b/%0d/%b want=00000000/0/0",
                               obs, stall_cycles, mem_timeout);
        end
        tick();
        tick();
        rst_n = 1'b1;
        imem_req = 1'b0;
        imem_resp = 1'b1;
        #3;
        checks++;
        if (obs !== 8'b0) begin
            errors++; $display("FAIL squash_forgotten got=%b want=%b", obs, 8'b0);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_dmem_wait();
        test_branch_in_dwait();
        test_squash();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
